// File: rtl/row_sweep_controller_pkg.sv
// Shared types and helpers for the row sweep controller: FSM states,
// sweep direction, default geometry and the segment mask builder.
package row_sweep_controller_pkg;

  localparam int unsigned ROW_WIDTH_DEF = 8;
  localparam int unsigned MAX_LEVEL_DEF = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SWEEP,
    S_EVAL,
    S_COMMIT_GO,
    S_COMMIT_RES,
    S_OVER
  } state_t;

  typedef enum logic {
    DIR_RIGHT,
    DIR_LEFT
  } dir_t;

  // wid contiguous ones starting at cell pos; callers truncate to the row width
  function automatic logic [63:0] seg_mask(input int unsigned wid, input int unsigned pos);
    logic [63:0] ones;
    ones = (64'd1 << wid) - 64'd1;
    return ones << pos;
  endfunction

endpackage

// File: rtl/row_sweep_controller_if.sv
// Player/level-FSM side bundle of the row sweep controller.
interface row_sweep_controller_if
  import row_sweep_controller_pkg::*;
#(
  parameter int unsigned ROW_WIDTH = ROW_WIDTH_DEF
);
  logic                 start;
  logic                 drop;
  logic [10:0]          speed_count;
  logic [3:0]           num_blocks;
  logic [5:0]           curr_level;
  logic                 go;
  logic                 next_signal;
  logic [ROW_WIDTH-1:0] row_mask;
  logic [ROW_WIDTH-1:0] stack_mask;
  logic [3:0]           row_idx;
  logic                 game_over;
  logic                 win;

  modport master (
    output start, drop, speed_count, num_blocks, curr_level,
    input  go, next_signal, row_mask, stack_mask, row_idx, game_over, win
  );

  modport slave (
    input  start, drop, speed_count, num_blocks, curr_level,
    output go, next_signal, row_mask, stack_mask, row_idx, game_over, win
  );
endinterface

// File: rtl/row_sweep_controller_frame_tick_gen.sv
// Frame tick divider: one-cycle tick every FRAME_DIV clocks while enabled.
module row_sweep_controller_frame_tick_gen #(
  parameter int unsigned FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          at_end;

  assign at_end = (cnt == CW'(FRAME_DIV - 1));
  assign tick   = en && at_end;

  always_ff @(posedge clk) begin
    if (resetn || clr || !en) begin
      cnt <= '0;
    end else if (at_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/row_sweep_controller.sv
// Row sweep controller: bounces the active segment across the row, captures it
// on drop, checks overlap with the stack and hands go/next_signal to the level FSM.
module row_sweep_controller
  import row_sweep_controller_pkg::*;
#(
  parameter int unsigned ROW_WIDTH = ROW_WIDTH_DEF,
  parameter int unsigned FRAME_DIV = 833333,
  parameter int unsigned MAX_LEVEL = MAX_LEVEL_DEF
) (
  input logic                  clk,
  input logic                  resetn,
  row_sweep_controller_if.slave bus
);
  localparam int unsigned PW = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
  localparam int unsigned WW = $clog2(ROW_WIDTH + 1);

  state_t               state, state_n;
  dir_t                 dir, dir_mv;
  logic [PW-1:0]        pos, pos_mv;
  logic [WW-1:0]        wid, wid_n;
  logic [10:0]          spd, spd_n, step;
  logic [ROW_WIDTH-1:0] row_mask, stack_mask, ov;
  logic [3:0]           row_idx;
  logic                 pass, win;
  logic                 go, next_signal, game_over;
  logic                 tick, tick_en, tick_clr;
  int unsigned          nb_c;

  assign tick_en  = (state == S_SWEEP);
  assign tick_clr = (state == S_LOAD);

  row_sweep_controller_frame_tick_gen #(
    .FRAME_DIV(FRAME_DIV)
  ) u_tick (
    .clk   (clk),
    .resetn(resetn),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (resetn) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    go          = 1'b0;
    next_signal = 1'b0;
    game_over   = 1'b0;
    unique case (state)
      S_IDLE:       if (bus.start) state_n = S_LOAD;
      S_LOAD:       state_n = S_SWEEP;
      S_SWEEP:      if (bus.drop) state_n = S_EVAL;
      S_EVAL:       state_n = S_COMMIT_GO;
      S_COMMIT_GO: begin
        go      = 1'b1;
        state_n = S_COMMIT_RES;
      end
      S_COMMIT_RES: begin
        next_signal = pass;
        state_n     = (pass && (32'(bus.curr_level) < MAX_LEVEL)) ? S_LOAD : S_OVER;
      end
      S_OVER: begin
        game_over = 1'b1;
        if (bus.start) state_n = S_LOAD;
      end
      default:      state_n = S_IDLE;
    endcase
  end

  always_comb begin
    spd_n = (bus.speed_count == '0) ? 11'd1 : bus.speed_count;
    nb_c  = 32'(bus.num_blocks);
    if (nb_c == 0)              nb_c = 1;
    else if (nb_c > ROW_WIDTH)  nb_c = ROW_WIDTH;
    wid_n = WW'(nb_c);
  end

  // Next position on a move; a full-width segment has nowhere to go
  always_comb begin
    pos_mv = pos;
    dir_mv = dir;
    if (32'(wid) != ROW_WIDTH) begin
      if (dir == DIR_RIGHT) begin
        if (32'(pos) + 32'(wid) == ROW_WIDTH) begin
          dir_mv = DIR_LEFT;
          pos_mv = pos - PW'(1);
        end else begin
          pos_mv = pos + PW'(1);
        end
      end else begin
        if (pos == '0) begin
          dir_mv = DIR_RIGHT;
          pos_mv = pos + PW'(1);
        end else begin
          pos_mv = pos - PW'(1);
        end
      end
    end
  end

  assign ov = row_mask & stack_mask;

  always_ff @(posedge clk) begin
    if (resetn) begin
      pos        <= '0;
      dir        <= DIR_RIGHT;
      step       <= '0;
      spd        <= 11'd1;
      wid        <= WW'(1);
      row_mask   <= '0;
      stack_mask <= '1;
      pass       <= 1'b0;
      win        <= 1'b0;
      row_idx    <= '0;
    end else begin
      case (state)
        S_IDLE, S_OVER: begin
          if (bus.start) begin
            stack_mask <= '1;
            row_idx    <= '0;
            win        <= 1'b0;
          end
        end
        S_LOAD: begin
          spd      <= spd_n;
          wid      <= wid_n;
          pos      <= '0;
          dir      <= DIR_RIGHT;
          step     <= spd_n - 11'd1;
          row_mask <= ROW_WIDTH'(seg_mask(32'(wid_n), 0));
        end
        S_SWEEP: begin
          // A drop freezes the pre-tick mask, so a coincident move is discarded
          if (!bus.drop && tick) begin
            if (step == '0) begin
              step     <= spd - 11'd1;
              pos      <= pos_mv;
              dir      <= dir_mv;
              row_mask <= ROW_WIDTH'(seg_mask(32'(wid), 32'(pos_mv)));
            end else begin
              step <= step - 11'd1;
            end
          end
        end
        S_EVAL: begin
          pass <= |ov;
          if (|ov) stack_mask <= ov;
        end
        S_COMMIT_RES: begin
          if (pass) begin
            if (32'(bus.curr_level) < MAX_LEVEL) begin
              if (row_idx != 4'hF) row_idx <= row_idx + 4'd1;
            end else begin
              win <= 1'b1;
            end
          end else begin
            win <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.go          = go;
  assign bus.next_signal = next_signal;
  assign bus.game_over   = game_over;
  assign bus.row_mask    = row_mask;
  assign bus.stack_mask  = stack_mask;
  assign bus.row_idx     = row_idx;
  assign bus.win         = win;
endmodule

// File: tb/tb_row_sweep_controller.sv
// Randomized bench for row_sweep_controller: time-based bounce model, drop
// scoreboard consumed by a go/next_signal monitor, and a per-cycle sweep watcher.
module tb_row_sweep_controller;
  localparam int RW = 8;
  localparam int FD = 4;
  localparam int ML = 15;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  row_sweep_controller_if #(.ROW_WIDTH(RW)) bus ();

  row_sweep_controller #(
    .ROW_WIDTH(RW),
    .FRAME_DIV(FD),
    .MAX_LEVEL(ML)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    int         go_cyc;
    bit         abort;
    logic [7:0] mask;
    bit         pass;
    logic [7:0] stack;
    logic [3:0] ridx;
    bit         over;
    bit         win;
  } exp_t;

  exp_t q[$];

  int         sw_s, sw_spd, sw_w;
  bit         sw_active = 1'b0;
  logic [7:0] m_stack;
  int         m_ridx;
  logic [7:0] m_last_mask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int clampw(input int nb);
    return (nb == 0) ? 1 : ((nb > RW) ? RW : nb);
  endfunction

  function automatic int clamps(input int sc);
    return (sc == 0) ? 1 : sc;
  endfunction

  // Bounce path as a triangle wave over the free span
  function automatic logic [7:0] model_mask(input int w, input int moves);
    int span, k, p;
    logic [15:0] ones;
    span = RW - w;
    if (span == 0) p = 0;
    else begin
      k = moves % (2 * span);
      p = (k <= span) ? k : 2 * span - k;
    end
    ones = (16'd1 << w) - 16'd1;
    return 8'(ones) << p;
  endfunction

  // Moves applied by the edge q when LOAD was entered at edge s
  function automatic int moves_by(input int s, input int spd, input int q);
    if (q < s + 1) return 0;
    return ((q - s - 1) / FD) / spd;
  endfunction

  task automatic new_params(input bit aim, input int row);
    bus.speed_count = 11'($urandom_range(0, 3));
    bus.num_blocks  = 4'($urandom_range(0, 12));
    if (aim) bus.curr_level = (row >= 17) ? 6'd15 : 6'($urandom_range(0, 14));
    else     bus.curr_level = 6'($urandom_range(8, 20));
  endtask

  task automatic start_game(input bit aim);
    @(negedge clk);
    new_params(aim, 0);
    bus.start = 1'b1;
    sw_s      = cyc + 1;
    sw_spd    = clamps(int'(bus.speed_count));
    sw_w      = clampw(int'(bus.num_blocks));
    sw_active = 1'b1;
    m_stack   = 8'hFF;
    m_ridx    = 0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // mode 0 normal, 1 reset instead of drop, 2 reset while in COMMIT_GO
  task automatic play_row(input bit aim, input int mode, input int row, output bit cont);
    int d, p, lvl;
    logic [7:0] m, ov;
    bit ps;
    exp_t e;
    d = $urandom_range(2, 70);
    if (aim) begin
      for (int t = 0; t < 400; t++) begin
        if ((model_mask(sw_w, moves_by(sw_s, sw_spd, sw_s + d + t - 1)) & m_stack) != 8'h00) begin
          d = d + t;
          break;
        end
      end
    end
    p = sw_s + d;
    if (p - 1 >= cyc + 3 && $urandom_range(0, 2) == 0) begin
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    while (cyc < p - 1) @(negedge clk);
    sw_active = 1'b0;
    if (mode == 1) begin
      resetn = 1'b1;
      @(negedge clk);
      resetn  = 1'b0;
      m_stack = 8'hFF;
      m_ridx  = 0;
      @(posedge clk);
      #1;
      chk("sweep_reset_row_mask", bus.row_mask, 0);
      chk("sweep_reset_stack", bus.stack_mask, 32'hFF);
      chk("sweep_reset_game_over", bus.game_over, 0);
      chk("sweep_reset_row_idx", bus.row_idx, 0);
      cont = 1'b0;
      return;
    end
    m   = model_mask(sw_w, moves_by(sw_s, sw_spd, p - 1));
    ov  = m & m_stack;
    ps  = |ov;
    lvl = int'(bus.curr_level);
    e.go_cyc = p + 1;
    e.abort  = (mode == 2);
    e.mask   = m;
    e.pass   = ps;
    e.stack  = ps ? ov : m_stack;
    e.ridx   = (ps && lvl < ML && m_ridx < 15) ? 4'(m_ridx + 1) : 4'(m_ridx);
    e.over   = !(ps && lvl < ML);
    e.win    = ps;
    q.push_back(e);
    bus.drop = 1'b1;
    @(negedge clk);
    bus.drop = 1'b0;
    if (mode == 2) begin
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      resetn  = 1'b0;
      m_stack = 8'hFF;
      m_ridx  = 0;
      cont    = 1'b0;
      return;
    end
    m_stack     = e.stack;
    m_ridx      = int'(e.ridx);
    m_last_mask = m;
    while (cyc < p + 3) @(negedge clk);
    if (e.over) begin
      cont = 1'b0;
    end else begin
      new_params(aim, row + 1);
      sw_s      = p + 3;
      sw_spd    = clamps(int'(bus.speed_count));
      sw_w      = clampw(int'(bus.num_blocks));
      sw_active = 1'b1;
      cont      = 1'b1;
    end
  endtask

  // Sweep watcher
  always @(posedge clk) begin
    #1;
    if (sw_active && cyc >= sw_s + 1)
      chk("sweep_mask", bus.row_mask, model_mask(sw_w, moves_by(sw_s, sw_spd, cyc)));
  end

  // Scoreboard monitor keyed on go
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.go === 1'b1) begin
      if (q.size() == 0) begin
        chk("go_spurious", bus.go, 0);
      end else begin
        e = q.pop_front();
        chk("go_latency", cyc, e.go_cyc);
        chk("go_with_next_signal", bus.next_signal, 0);
        chk("captured_mask", bus.row_mask, e.mask);
        @(posedge clk);
        #1;
        chk("go_width", bus.go, 0);
        if (e.abort) begin
          chk("abort_next_signal", bus.next_signal, 0);
          chk("abort_row_mask", bus.row_mask, 0);
          chk("abort_stack", bus.stack_mask, 32'hFF);
          chk("abort_row_idx", bus.row_idx, 0);
          chk("abort_game_over", bus.game_over, 0);
        end else begin
          chk("next_signal", bus.next_signal, e.pass);
          chk("stack_mask", bus.stack_mask, e.stack);
          @(posedge clk);
          #1;
          chk("next_signal_width", bus.next_signal, 0);
          chk("game_over", bus.game_over, e.over);
          chk("row_idx", bus.row_idx, e.ridx);
          if (e.over) chk("win", bus.win, e.win);
        end
      end
    end
  end

  initial begin
    while (cyc < 90000) @(posedge clk);
    $display("FAIL watchdog: cycles %0d limit %0d", cyc, 90000);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    bit cont, aim;
    int mode;
    bus.start       = 1'b0;
    bus.drop        = 1'b0;
    bus.speed_count = 11'd2;
    bus.num_blocks  = 4'd1;
    bus.curr_level  = 6'd0;
    resetn          = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_go", bus.go, 0);
    chk("reset_next_signal", bus.next_signal, 0);
    chk("reset_row_mask", bus.row_mask, 0);
    chk("reset_stack_mask", bus.stack_mask, 32'hFF);
    chk("reset_game_over", bus.game_over, 0);
    chk("reset_row_idx", bus.row_idx, 0);
    chk("reset_win", bus.win, 0);

    for (int g = 0; g < 10; g++) begin
      aim = (g % 3 == 0);
      start_game(aim);
      cont = 1'b1;
      for (int row = 0; row < 24 && cont; row++) begin
        mode = 0;
        if (g == 1 && row == 0)      mode = 1;
        else if (g == 2 && row == 0) mode = 2;
        else if (!aim && $urandom_range(0, 15) == 0) mode = int'($urandom_range(1, 2));
        play_row(aim, mode, row, cont);
        if (!cont && mode == 0) begin
          bus.drop = 1'b1;
          @(negedge clk);
          bus.drop = 1'b0;
          repeat (3) @(negedge clk);
          chk("over_holds_game_over", bus.game_over, 1);
          chk("over_holds_row_mask", bus.row_mask, m_last_mask);
          chk("over_holds_stack", bus.stack_mask, m_stack);
        end
      end
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
